// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: owns the PC and runs a request/ready handshake to a
// variable-latency instruction memory. It keeps one returned instruction in a
// skid buffer and drives the IF/ID register. Branch redirects squash any
// response that is still in flight.
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stal_f,
    input  logic        i_stal_d,
    input  logic        i_flush_d,
    input  logic        i_pc_src_e,
    input  logic [31:0] i_pc_target_e,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_d,
    output logic [31:0] o_pc_plus4_d,
    output logic        o_valid_d,
    output logic        o_fetch_busy
);

    typedef enum logic [1:0] {StIdle, StReq, StSquash} state_e;

    state_e      r_state, w_state_d;
    logic [31:0] r_pc_f, w_pc_f_d;
    // Address of the outstanding request. It is kept apart from r_pc_f so that
    // a redirect during SQUASH cannot disturb the address on the bus.
    logic [31:0] r_req_addr, w_req_addr_d;
    logic        w_accept;

    logic        r_skid_valid, w_skid_valid_d;
    logic [31:0] r_skid_instr, w_skid_instr_d;
    logic [31:0] r_skid_pc, w_skid_pc_d;

    logic [31:0] r_instr_d, w_instr_d;
    logic [31:0] r_pc_d, w_pc_d;
    logic [31:0] r_pc_plus4_d, w_pc_plus4_d;
    logic        r_valid_d, w_valid_d;

    // State, PC and request-address registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_pc_f     <= RESET_PC;
            r_req_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_d;
            r_pc_f     <= w_pc_f_d;
            r_req_addr <= w_req_addr_d;
        end
    end

    // FSM next state, PC update and response acceptance
    always_comb begin
        w_state_d    = r_state;
        w_pc_f_d     = r_pc_f;
        w_req_addr_d = r_req_addr;
        w_accept     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_pc_src_e) begin
                    w_pc_f_d = i_pc_target_e;
                end else if (!i_stal_f && !r_skid_valid) begin
                    w_state_d    = StReq;
                    w_req_addr_d = r_pc_f;
                end
            end
            StReq: begin
                if (i_imem_ready) begin
                    w_state_d = StIdle;
                    if (i_pc_src_e) begin
                        // The response is on the wrong path, so drop it
                        w_pc_f_d = i_pc_target_e;
                    end else begin
                        w_accept = 1'b1;
                        w_pc_f_d = r_pc_f + 32'd4;
                    end
                end else if (i_pc_src_e) begin
                    w_pc_f_d  = i_pc_target_e;
                    w_state_d = StSquash;
                end
            end
            StSquash: begin
                if (i_pc_src_e) begin
                    w_pc_f_d = i_pc_target_e;
                end
                if (i_imem_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Skid buffer registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skid_valid <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= 32'd0;
        end else begin
            r_skid_valid <= w_skid_valid_d;
            r_skid_instr <= w_skid_instr_d;
            r_skid_pc    <= w_skid_pc_d;
        end
    end

    // Skid buffer next state: clear on redirect, flush or drain, fill on blocked accept
    always_comb begin
        w_skid_valid_d = r_skid_valid;
        w_skid_instr_d = r_skid_instr;
        w_skid_pc_d    = r_skid_pc;
        if (i_pc_src_e || i_flush_d) begin
            w_skid_valid_d = 1'b0;
        end else if (!i_stal_d && r_skid_valid) begin
            w_skid_valid_d = 1'b0;
        end
        // Accept only happens in REQ, where the buffer is always empty
        if (w_accept && (i_stal_d || i_flush_d)) begin
            w_skid_valid_d = 1'b1;
            w_skid_instr_d = i_imem_rdata;
            w_skid_pc_d    = r_req_addr;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= 32'd0;
            r_pc_plus4_d <= 32'd0;
            r_valid_d    <= 1'b0;
        end else begin
            r_instr_d    <= w_instr_d;
            r_pc_d       <= w_pc_d;
            r_pc_plus4_d <= w_pc_plus4_d;
            r_valid_d    <= w_valid_d;
        end
    end

    // IF/ID next state: flush > stall > skid buffer > accepted response > bubble
    always_comb begin
        w_instr_d    = r_instr_d;
        w_pc_d       = r_pc_d;
        w_pc_plus4_d = r_pc_plus4_d;
        w_valid_d    = r_valid_d;
        if (i_flush_d) begin
            w_instr_d = NOP_INSTR;
            w_valid_d = 1'b0;
        end else if (i_stal_d) begin
            w_valid_d = r_valid_d;
        end else if (r_skid_valid) begin
            w_instr_d    = r_skid_instr;
            w_pc_d       = r_skid_pc;
            w_pc_plus4_d = r_skid_pc + 32'd4;
            w_valid_d    = 1'b1;
        end else if (w_accept) begin
            w_instr_d    = i_imem_rdata;
            w_pc_d       = r_req_addr;
            w_pc_plus4_d = r_req_addr + 32'd4;
            w_valid_d    = 1'b1;
        end else begin
            w_instr_d = NOP_INSTR;
            w_valid_d = 1'b0;
        end
    end

    // Output drive
    always_comb begin
        o_imem_req   = (r_state != StIdle);
        o_imem_addr  = r_req_addr;
        o_fetch_busy = o_imem_req && !i_imem_ready;
        o_instr_d    = r_instr_d;
        o_pc_d       = r_pc_d;
        o_pc_plus4_d = r_pc_plus4_d;
        o_valid_d    = r_valid_d;
    end

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
- Fetch-side consumer of the pipeline hazard controls (stal_f, stal_d, flush_d, pc_src_e).
- Owns the PC register and drives a request/ready handshake to a variable-latency instruction memory.
- Holds one returned instruction in a skid buffer and drives the IF/ID pipeline register (instr_d, pc_d, pc_plus4_d, valid_d) for the decode stage.
- Applies branch redirects, including squashing an instruction-memory response that is already in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) written to instr_d on flush or empty fetch

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
stal_f  input  1  hold PC and suppress new fetch launch
stal_d  input  1  hold IF/ID register
flush_d  input  1  replace IF/ID contents with bubble
pc_src_e  input  1  redirect taken in execute
pc_target_e  input  32  redirect target
imem_req  output  1  fetch request, held until imem_ready
imem_addr  output  32  fetch address, stable while imem_req=1
imem_ready  input  1  one-cycle response strobe, valid only while imem_req=1
imem_rdata  input  32  instruction, valid with imem_ready
instr_d  output  32  IF/ID instruction
pc_d  output  32  IF/ID PC
pc_plus4_d  output  32  IF/ID PC+4
valid_d  output  1  IF/ID holds a real instruction
fetch_busy  output  1  imem_req=1 and imem_ready=0 (status only)

Behaviour:
- Reset (async, rst_n=0):
  - pc_f=RESET_PC; instr_d=NOP_INSTR; pc_d=0; pc_plus4_d=0; valid_d=0.
  - imem_req=0; skid buffer empty; squash flag clear; state=IDLE.
- FSM states: IDLE, REQ, SQUASH.
  - IDLE: imem_req=0. Go to REQ when stal_f=0, skid buffer empty, and pc_src_e=0. If pc_src_e=1, apply the redirect and stay in IDLE for that cycle.
  - REQ: imem_req=1, imem_addr=pc_f; the address is registered and does not change in this state.
    - On imem_ready with pc_src_e=0: the response is accepted; go to IDLE.
    - pc_src_e=1 without imem_ready: pc_f<=pc_target_e; go to SQUASH.
    - pc_src_e=1 together with imem_ready: discard the response; pc_f<=pc_target_e; go to IDLE.
  - SQUASH: imem_req=1 at the old address. On imem_ready, drop imem_rdata and go to IDLE. Further pc_src_e in SQUASH overwrites pc_f.
- Accepted response (REQ, imem_ready=1, pc_src_e=0):
  - If the IF/ID register is free to load (stal_d=0 and flush_d=0), load it directly: instr_d=imem_rdata, pc_d=fetched pc, pc_plus4_d=fetched pc+4 (mod 2^32), valid_d=1.
  - Otherwise write the response to the skid buffer.
  - In both cases pc_f<=pc_f+4 on the same edge.
- IF/ID update priority, evaluated each edge:
  1. flush_d=1: instr_d=NOP_INSTR, valid_d=0. The skid buffer is cleared. flush_d wins over stal_d.
  2. stal_d=1: hold all IF/ID outputs.
  3. Skid buffer valid: load from the buffer and clear it.
  4. Accepted response this cycle: load as above.
  5. Otherwise: bubble (NOP_INSTR, valid_d=0).
- Redirect:
  - pc_src_e=1 has priority over stal_f and over the PC+4 advance.
  - It clears the skid buffer in the same cycle.
- Latency: with single-cycle memory (ready the cycle after req) and no stalls, one instruction reaches decode every 2 cycles (REQ then IDLE). Throughput-1 pipelining is out of scope.
- stal_f=1 only blocks IDLE->REQ. An outstanding request always completes.
- Wrap-around: pc 32'hFFFF_FFFC+4 = 0, with no error.
- Reset mid-request: imem_req drops immediately (async). The memory model must tolerate an abandoned request.

Test Plan:
- Reset release with imem_ready one cycle after each req -> imem_addr sequence 0,4,8; decode receives rdata 0xA,0xB,0xC with pc_d 0,4,8 and valid_d=1 on each load, bubbles between loads.
- imem_ready delayed 3 cycles at addr 0x10 -> imem_addr stays 0x10 and fetch_busy=1 for 3 cycles; instr_d=NOP_INSTR, valid_d=0 until the load.
- stal_d=1 in the imem_ready cycle for addr 0x20, released 2 cycles later -> no new req while the buffer is full; IF/ID is held, then loads 0x20's instruction on the cycle after release.
- pc_src_e=1 with pc_target_e=0x100 while req to 0x40 is pending, ready 2 cycles later -> addr-0x40 response is discarded; next imem_addr=0x100; valid_d never shows 0x40.
- flush_d=1 and stal_d=1 in the same cycle -> instr_d=NOP_INSTR, valid_d=0 next edge.
- rst_n low mid-request at pc=0x80 -> imem_req=0 and valid_d=0 asynchronously; after release the first imem_addr=RESET_PC.
